// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - round-robin arbiter sharing one data-memory port between CPU and debug port
// Optional statistics counters are enabled by defining ARB_STATS_EN.
module dmem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_done_o,
  output logic              cpu_stall_o,
  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  output logic [DATA_W-1:0] dbg_rdata_o,
  output logic              dbg_done_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       dbg_grant_cnt_o
`endif
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;
  localparam logic [3:0] LAT_LOAD  = 4'(MEM_LAT - 1);

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;       // 0 = CPU, 1 = debug
  logic              last_q, last_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
  logic              grant;
  logic              grant_dbg;
  logic              last_acc;
  logic [DATA_W-1:0] cap_data;

  assign last_acc = (state_q == ST_ACCESS) && (cnt_q == 4'd0);
  assign cap_data = we_q ? '0 : mem_rdata_i;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    grant       = 1'b0;
    grant_dbg   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i && (cpu_req_i || dbg_req_i)) begin
          grant     = 1'b1;
          // On a tie the requester that did not win last time gets the port.
          grant_dbg = (cpu_req_i && dbg_req_i) ? ~last_q : dbg_req_i;
          owner_d   = grant_dbg;
          last_d    = grant_dbg;
          we_d      = grant_dbg ? dbg_we_i    : cpu_we_i;
          addr_d    = grant_dbg ? dbg_addr_i  : cpu_addr_i;
          wdata_d   = grant_dbg ? dbg_wdata_i : cpu_wdata_i;
          cnt_d     = LAT_LOAD;
          state_d   = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_DONE;
          if (owner_q) dbg_rdata_d = cap_data;
          else         cpu_rdata_d = cap_data;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= 4'd0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  assign mem_en_o    = (state_q == ST_ACCESS);
  assign mem_we_o    = mem_en_o & we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign cpu_done_o  = (state_q == ST_DONE) & ~owner_q;
  assign dbg_done_o  = (state_q == ST_DONE) & owner_q;
  assign cpu_stall_o = cpu_req_i & ~cpu_done_o;
  assign cpu_rdata_o = cpu_rdata_q;
  assign dbg_rdata_o = dbg_rdata_q;

`ifdef ARB_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] grant_cnt_q, grant_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    grant_cnt_d = grant_cnt_q;
    if (cpu_stall_o && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
    if (grant && grant_dbg && (grant_cnt_q != 32'hFFFF_FFFF)) grant_cnt_d = grant_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_q <= '0;
      grant_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      grant_cnt_q <= grant_cnt_d;
    end
  end

  assign stall_cnt_o     = stall_cnt_q;
  assign dbg_grant_cnt_o = grant_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - table-driven bench for dmem_port_arbiter (MEM_LAT=2)
module tb_dmem_port_arbiter;
  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        start_i, cpu_req_i, cpu_we_i, dbg_req_i, dbg_we_i;
  logic [31:0] cpu_addr_i, cpu_wdata_i, dbg_addr_i, dbg_wdata_i;
  logic [31:0] cpu_rdata_o, dbg_rdata_o, mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic        cpu_done_o, cpu_stall_o, dbg_done_o, mem_en_o, mem_we_o;
`ifdef ARB_STATS_EN
  logic [31:0] stall_cnt_o, dbg_grant_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_wdata_i(cpu_wdata_i), .cpu_rdata_o(cpu_rdata_o), .cpu_done_o(cpu_done_o),
    .cpu_stall_o(cpu_stall_o), .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i),
    .dbg_addr_i(dbg_addr_i), .dbg_wdata_i(dbg_wdata_i), .dbg_rdata_o(dbg_rdata_o),
    .dbg_done_o(dbg_done_o), .mem_en_o(mem_en_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
`ifdef ARB_STATS_EN
    , .stall_cnt_o(stall_cnt_o), .dbg_grant_cnt_o(dbg_grant_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Small behavioural memory: 16 words, read combinationally while enabled.
  logic [31:0] mem [16];
  assign mem_rdata_i = mem_en_o ? mem[mem_addr_o[5:2]] : 32'd0;
  always @(posedge clk_i) if (mem_en_o && mem_we_o) mem[mem_addr_o[5:2]] <= mem_wdata_o;

  typedef struct {
    logic        start, creq, cwe;
    logic [31:0] caddr, cwdata;
    logic        dreq, dwe;
    logic [31:0] daddr, dwdata;
    logic        e_en, e_we;
    logic [31:0] e_addr;
    logic        e_cdone, e_stall;
    logic [31:0] e_crd;
    logic        e_ddone;
    logic [31:0] e_drd;
  } vec_t;

  vec_t vq[$];

  localparam logic [31:0] A2 = 32'hA0A0_0002;
  localparam logic [31:0] B3 = 32'hB0B0_0003;
  localparam logic [31:0] DB = 32'hDEAD_BEEF;

  task automatic add(input logic st, input logic cr, input logic cw, input logic [31:0] ca,
                     input logic [31:0] cd, input logic dr, input logic dw, input logic [31:0] da,
                     input logic [31:0] dd, input logic en, input logic we, input logic [31:0] ad,
                     input logic cdn, input logic stl, input logic [31:0] crd,
                     input logic ddn, input logic [31:0] drd);
    vec_t v;
    v.start = st; v.creq = cr; v.cwe = cw; v.caddr = ca; v.cwdata = cd;
    v.dreq = dr; v.dwe = dw; v.daddr = da; v.dwdata = dd;
    v.e_en = en; v.e_we = we; v.e_addr = ad; v.e_cdone = cdn; v.e_stall = stl;
    v.e_crd = crd; v.e_ddone = ddn; v.e_drd = drd;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] outs();
    return {26'd0, mem_en_o, mem_we_o, mem_addr_o, cpu_done_o, cpu_stall_o, cpu_rdata_o,
            dbg_done_o, dbg_rdata_o};
  endfunction

  initial begin
    int stall_exp;
    int n;
    bit got;
    for (int i = 0; i < 16; i++) mem[i] = 32'd0;
    mem[0] = 32'd5; mem[2] = A2; mem[3] = B3;

    // tie: CPU first, then CPU re-requests while debug waits -> debug wins
    add(1,1,0,8,0, 1,0,'hC,0, 0,0,0,   0,1,0,  0,0);
    add(1,1,0,8,0, 1,0,'hC,0, 1,0,8,   0,1,0,  0,0);
    add(1,1,0,8,0, 1,0,'hC,0, 1,0,8,   0,1,0,  0,0);
    add(1,0,0,0,0, 1,0,'hC,0, 0,0,8,   1,0,A2, 0,0);
    add(1,1,0,0,0, 1,0,'hC,0, 0,0,8,   0,1,A2, 0,0);
    add(1,1,0,0,0, 1,0,'hC,0, 1,0,'hC, 0,1,A2, 0,0);
    add(1,1,0,0,0, 1,0,'hC,0, 1,0,'hC, 0,1,A2, 0,0);
    add(1,1,0,0,0, 0,0,0,0,   0,0,'hC, 0,1,A2, 1,B3);
    // CPU read of 0x00 (holds 5): en cycles 1-2, done cycle 3
    add(1,1,0,0,0, 0,0,0,0,   0,0,'hC, 0,1,A2, 0,B3);
    add(1,1,0,0,0, 0,0,0,0,   1,0,0,   0,1,A2, 0,B3);
    add(1,1,0,0,0, 0,0,0,0,   1,0,0,   0,1,A2, 0,B3);
    add(1,0,0,0,0, 0,0,0,0,   0,0,0,   1,0,5,  0,B3);
    // debug write 0x04 <= DEADBEEF, then CPU read back
    add(1,0,0,0,0, 1,1,4,DB,  0,0,0,   0,0,5,  0,B3);
    add(1,0,0,0,0, 1,1,4,DB,  1,1,4,   0,0,5,  0,B3);
    add(1,0,0,0,0, 1,1,4,DB,  1,1,4,   0,0,5,  0,B3);
    add(1,0,0,0,0, 0,0,0,0,   0,0,4,   0,0,5,  1,0);
    add(1,1,0,4,0, 0,0,0,0,   0,0,4,   0,1,5,  0,0);
    add(1,1,0,4,0, 0,0,0,0,   1,0,4,   0,1,5,  0,0);
    add(1,1,0,4,0, 0,0,0,0,   1,0,4,   0,1,5,  0,0);
    add(1,0,0,0,0, 0,0,0,0,   0,0,4,   1,0,DB, 0,0);
    // start_i low blocks grants; dropping it mid-access does not abort
    add(0,1,0,8,0, 0,0,0,0,   0,0,4,   0,1,DB, 0,0);
    add(0,1,0,8,0, 0,0,0,0,   0,0,4,   0,1,DB, 0,0);
    add(0,1,0,8,0, 0,0,0,0,   0,0,4,   0,1,DB, 0,0);
    add(1,1,0,8,0, 0,0,0,0,   0,0,4,   0,1,DB, 0,0);
    add(1,1,0,8,0, 0,0,0,0,   1,0,8,   0,1,DB, 0,0);
    add(0,1,0,8,0, 0,0,0,0,   1,0,8,   0,1,DB, 0,0);
    add(0,0,0,0,0, 0,0,0,0,   0,0,8,   1,0,A2, 0,0);
    // debug drops req during access: still completes and pulses done
    add(1,0,0,0,0, 1,0,8,0,   0,0,8,   0,0,A2, 0,0);
    add(1,0,0,0,0, 0,0,0,0,   1,0,8,   0,0,A2, 0,0);
    add(1,0,0,0,0, 0,0,0,0,   1,0,8,   0,0,A2, 0,0);
    add(1,0,0,0,0, 0,0,0,0,   0,0,8,   0,0,A2, 1,A2);
    add(1,0,0,0,0, 0,0,0,0,   0,0,8,   0,0,A2, 0,A2);

    rst_n_i = 1'b0; start_i = 1'b0; cpu_req_i = 1'b0; cpu_we_i = 1'b0; dbg_req_i = 1'b0;
    dbg_we_i = 1'b0; cpu_addr_i = '0; cpu_wdata_i = '0; dbg_addr_i = '0; dbg_wdata_i = '0;
    repeat (2) @(negedge clk_i);
    check("reset_outputs", outs(), 128'd0);
    rst_n_i = 1'b1;

    stall_exp = 0;
    foreach (vq[i]) begin
      @(negedge clk_i);
      start_i = vq[i].start; cpu_req_i = vq[i].creq; cpu_we_i = vq[i].cwe;
      cpu_addr_i = vq[i].caddr; cpu_wdata_i = vq[i].cwdata; dbg_req_i = vq[i].dreq;
      dbg_we_i = vq[i].dwe; dbg_addr_i = vq[i].daddr; dbg_wdata_i = vq[i].dwdata;
      #1;
      if (vq[i].e_stall) stall_exp++;
      check($sformatf("vec%0d", i), outs(),
            {26'd0, vq[i].e_en, vq[i].e_we, vq[i].e_addr, vq[i].e_cdone, vq[i].e_stall,
             vq[i].e_crd, vq[i].e_ddone, vq[i].e_drd});
    end

`ifdef ARB_STATS_EN
    check("stall_cnt", {96'd0, stall_cnt_o}, 128'(stall_exp));
    check("dbg_grant_cnt", {96'd0, dbg_grant_cnt_o}, 128'd3);
`endif

    // reset during the first ACCESS cycle
    @(negedge clk_i);
    dbg_req_i = 1'b0; start_i = 1'b1; cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'd0;
    #1 check("rst_pre_idle", {127'd0, mem_en_o}, 128'd0);
    @(negedge clk_i);
    #1 check("rst_access_en", {127'd0, mem_en_o}, 128'd1);
    #2 rst_n_i = 1'b0;
    #1 check("rst_async_drop", {126'd0, mem_en_o, cpu_done_o}, 128'd0);
    @(negedge clk_i);
    #1 check("rst_no_done", {126'd0, mem_en_o, cpu_done_o}, 128'd0);
    check("rst_rdata_clear", {64'd0, cpu_rdata_o, dbg_rdata_o}, 128'd0);
    rst_n_i = 1'b1;
    n = 0; got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk_i);
      #1 n++;
      if (cpu_done_o) got = 1'b1;
    end
    check("rerequest_latency", {96'd0, got ? n : -1}, 128'd3);
    check("rerequest_rdata", {96'd0, cpu_rdata_o}, 128'd5);
    cpu_req_i = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
